// File: rtl/uart_tx_word_arbiter.sv
// uart_tx_word_arbiter: round-robin share of one UART TX between two word producers, sent MSB-first byte by byte
// Ports: i_clock (negedge), i_reset (sync, active-high); req0/req1 valid/data in, ready pulse out;
//        o_tx_data/o_tx_start/i_tx_done to the UART TX; o_grant one-hot owner, o_busy, o_timeout.
// Optional: define TX_WORD_TIMEOUT_EN to add the SEND watchdog (TIMEOUT_CYCLES); otherwise o_timeout stays 0.
module uart_tx_word_arbiter #(
  parameter int N_BITS         = 8,
  parameter int NB_DATA        = 32,
  parameter int N_BYTES        = NB_DATA / N_BITS,
  parameter int NB_BYTE_CTR    = 2,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_req0_valid,
  input  logic [NB_DATA-1:0] i_req0_data,
  output logic               o_req0_ready,
  input  logic               i_req1_valid,
  input  logic [NB_DATA-1:0] i_req1_data,
  output logic               o_req1_ready,
  output logic [N_BITS-1:0]  o_tx_data,
  output logic               o_tx_start,
  input  logic               i_tx_done,
  output logic [1:0]         o_grant,
  output logic               o_busy,
  output logic               o_timeout
);
  typedef enum logic [1:0] {IDLE, LOAD, SEND, GAP} state_t;
  if (NB_DATA != N_BYTES * N_BITS || (1 << NB_BYTE_CTR) < N_BYTES ||
      TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_cfg
    $error("uart_tx_word_arbiter: inconsistent parameters");
  end
  state_t                 state_q;
  logic [NB_DATA-1:0]     word_q, win_data, shifted;
  logic [NB_BYTE_CTR-1:0] byte_cnt_q, byte_cnt_d;
  logic [N_BITS-1:0]      tx_data_q;
  logic [1:0]             grant_q;
  logic                   last_grant_q, last_byte_q, tx_start_q, ready0_q, ready1_q, timeout_q;
  logic                   pick0, pick1, last_cnt, wd_expire;
  // last_grant_q resets to 1 so the first tie favours requester 0
  assign pick0      = i_req0_valid & (~i_req1_valid | last_grant_q);
  assign pick1      = i_req1_valid & ~pick0;
  assign win_data   = grant_q[0] ? i_req0_data : i_req1_data;
  assign shifted    = word_q << (N_BITS * int'(byte_cnt_q));
  assign byte_cnt_d = byte_cnt_q + 1'b1;
  assign last_cnt   = byte_cnt_q == NB_BYTE_CTR'(N_BYTES - 1);
`ifdef TX_WORD_TIMEOUT_EN
  logic [15:0] wdog_q;
  assign wd_expire = wdog_q == 16'(TIMEOUT_CYCLES - 1);
  // held at zero outside SEND, so it restarts on every entry to SEND
  always_ff @(negedge i_clock)
    wdog_q <= (i_reset || state_q != SEND) ? '0 : wdog_q + 16'd1;
`else
  assign wd_expire = 1'b0;
`endif
  always_ff @(negedge i_clock) begin
    if (i_reset) begin
      state_q      <= IDLE;
      word_q       <= '0;
      byte_cnt_q   <= '0;
      last_grant_q <= 1'b1;
      last_byte_q  <= 1'b0;
      grant_q      <= '0;
      tx_data_q    <= '0;
      tx_start_q   <= 1'b0;
      ready0_q     <= 1'b0;
      ready1_q     <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      ready0_q  <= 1'b0;
      ready1_q  <= 1'b0;
      timeout_q <= 1'b0;
      case (state_q)
        IDLE: if (pick0 | pick1) begin
          grant_q      <= {pick1, pick0};
          last_grant_q <= pick1;
          state_q      <= LOAD;
        end
        LOAD: begin
          word_q      <= win_data;
          ready0_q    <= grant_q[0];
          ready1_q    <= grant_q[1];
          byte_cnt_q  <= '0;
          last_byte_q <= 1'b0;
          tx_data_q   <= win_data[NB_DATA-1 -: N_BITS];
          tx_start_q  <= 1'b1;
          state_q     <= SEND;
        end
        SEND: if (i_tx_done) begin
          tx_start_q  <= 1'b0;
          last_byte_q <= last_cnt;
          if (!last_cnt) byte_cnt_q <= byte_cnt_d;
          state_q     <= GAP;
        end else if (wd_expire) begin
          tx_start_q <= 1'b0;
          timeout_q  <= 1'b1;
          grant_q    <= '0;
          byte_cnt_q <= '0;
          state_q    <= IDLE;
        end
        default: if (last_byte_q) begin
          grant_q    <= '0;
          byte_cnt_q <= '0;
          state_q    <= IDLE;
        end else begin
          tx_data_q  <= shifted[NB_DATA-1 -: N_BITS];
          tx_start_q <= 1'b1;
          state_q    <= SEND;
        end
      endcase
    end
  end
  assign o_req0_ready = ready0_q;
  assign o_req1_ready = ready1_q;
  assign o_tx_data    = tx_data_q;
  assign o_tx_start   = tx_start_q;
  assign o_grant      = grant_q;
  assign o_busy       = state_q != IDLE;
  assign o_timeout    = timeout_q;
endmodule

// File: tb/tb_uart_tx_word_arbiter.sv
// tb_uart_tx_word_arbiter: directed scoreboard bench for uart_tx_word_arbiter
module tb_uart_tx_word_arbiter;
  localparam int TO = 10;
  logic        clk = 1'b0, rst = 1'b1, v0 = 1'b0, v1 = 1'b0, done = 1'b0;
  logic [31:0] d0 = '0, d1 = '0;
  logic        r0, r1, start, busy, tmo;
  logic [7:0]  txd;
  logic [1:0]  grant;
  int          checks = 0, failures = 0, r0_cnt = 0, r1_cnt = 0, n_to = 0;
  logic [31:0] q0[$], q1[$];
  logic [7:0]  exp_b[$];
  logic [1:0]  gseq[$];
  logic        model_last = 1'b1;
  bit          stall = 1'b0;

  uart_tx_word_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .i_clock(clk), .i_reset(rst),
    .i_req0_valid(v0), .i_req0_data(d0), .o_req0_ready(r0),
    .i_req1_valid(v1), .i_req1_data(d1), .o_req1_ready(r1),
    .o_tx_data(txd), .o_tx_start(start), .i_tx_done(done),
    .o_grant(grant), .o_busy(busy), .o_timeout(tmo)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    v0 = q0.size() > 0;
    d0 = v0 ? q0[0] : '0;
    v1 = q1.size() > 0;
    d1 = v1 ? q1[0] : '0;
  endtask

  task automatic do_reset();
    rst = 1'b1; done = 1'b0; stall = 1'b0;
    q0.delete(); q1.delete(); exp_b.delete();
    drive();
    repeat (2) @(posedge clk);
    chk("rst_start", start, 0);
    chk("rst_txdata", txd, 0);
    chk("rst_ready", {r1, r0}, 0);
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_timeout", tmo, 0);
    rst = 1'b0;
    model_last = 1'b1;
  endtask

  // UART model plus scoreboard; returns when idle with nothing pending,
  // or right after the stop_bytes-th completed byte when stop_bytes > 0
  task automatic run(int dly, int stop_bytes, int budget);
    int w = -1, nb = 0, since = 0;
    bit gap_pending = 1'b0;
    logic prev_start = 1'b0, w1;
    logic [1:0] owner = 2'b00;
    logic [31:0] word;
    for (int c = 0; c < budget; c++) begin
      @(posedge clk);
      since++;
      if (gap_pending) begin
        chk("gap_low", start, 0);
        done = 1'b0;
        gap_pending = 1'b0;
        nb++;
        if (stop_bytes != 0 && nb == stop_bytes) return;
      end
      if (r0 || r1) begin
        r0_cnt += int'(r0);
        r1_cnt += int'(r1);
        w1 = (q0.size() > 0 && q1.size() > 0) ? !model_last : (q1.size() > 0);
        chk("ready_pending", q0.size() + q1.size(), (q0.size() + q1.size() > 0) ? q0.size() + q1.size() : 1);
        chk("ready_winner", {r1, r0}, w1 ? 2'b10 : 2'b01);
        chk("ready_grant", grant, w1 ? 2'b10 : 2'b01);
        owner = w1 ? 2'b10 : 2'b01;
        model_last = w1;
        gseq.push_back(grant);
        word = w1 ? (q1.size() > 0 ? q1.pop_front() : '0) : (q0.size() > 0 ? q0.pop_front() : '0);
        for (int i = 0; i < 4; i++) exp_b.push_back(word[31 - 8 * i -: 8]);
        drive();
      end
      if (tmo) begin
`ifdef TX_WORD_TIMEOUT_EN
        chk("timeout_cycles", since, TO);
        chk("timeout_start", start, 0);
        chk("timeout_grant", grant, 0);
`else
        chk("timeout_off", tmo, 0);
`endif
        exp_b.delete();
        stall = 1'b0;
        n_to++;
        w = -1;
        owner = 2'b00;
      end
      if (start && !prev_start) begin
        chk("byte", {24'h0, txd}, exp_b.size() > 0 ? {24'h0, exp_b.pop_front()} : 32'h100);
        chk("byte_grant", grant, owner);
        since = 0;
        w = 0;
      end
      prev_start = start;
      if (start && w >= 0 && !stall) begin
        if (w == dly) begin
          done = 1'b1;
          gap_pending = 1'b1;
          w = -1;
        end else w++;
      end
      if (!busy && q0.size() == 0 && q1.size() == 0 && exp_b.size() == 0 && !gap_pending) return;
    end
    checks++;
    failures++;
    $error("FAIL run_budget: no idle within %0d cycles, busy=%0b pending_bytes=%0d", budget, busy, exp_b.size());
  endtask

  initial begin
    do_reset();
    // 1: single word from req0, done 3 cycles after each start
    q0.push_back(32'hDEADBEEF);
    drive();
    @(posedge clk);
    chk("t1_load_grant", grant, 2'b01);
    chk("t1_load_busy", busy, 1);
    chk("t1_load_ready", r0, 0);
    chk("t1_load_start", start, 0);
    run(3, 0, 200);
    chk("t1_ready_cnt", r0_cnt, 1);
    chk("t1_end_grant", grant, 0);
    chk("t1_end_busy", busy, 0);
    // 2: simultaneous requests after reset, req0 first
    do_reset();
    r0_cnt = 0; r1_cnt = 0; gseq.delete();
    q0.push_back(32'h11223344);
    q1.push_back(32'hAABBCCDD);
    drive();
    run(3, 0, 300);
    chk("t2_r0_cnt", r0_cnt, 1);
    chk("t2_r1_cnt", r1_cnt, 1);
    chk("t2_first", gseq.size() > 0 ? gseq[0] : 2'b11, 2'b01);
    // 3: continuous valids, done in the same cycle start rises
    gseq.delete();
    q0.push_back(32'h01020304); q0.push_back(32'h05060708);
    q1.push_back(32'hF1F2F3F4); q1.push_back(32'hF5F6F7F8);
    drive();
    run(0, 0, 400);
    chk("t3_words", gseq.size(), 4);
    for (int i = 0; i < 4 && i < gseq.size(); i++) chk("t3_alternate", gseq[i], i[0] ? 2'b10 : 2'b01);
    // 4: reset after the second byte completes
    q1.push_back(32'h9A8B7C6D);
    drive();
    run(2, 2, 200);
    rst = 1'b1;
    q0.delete(); q1.delete(); exp_b.delete();
    drive();
    @(posedge clk);
    chk("t4_start", start, 0);
    chk("t4_busy", busy, 0);
    chk("t4_grant", grant, 0);
    rst = 1'b0;
    model_last = 1'b1;
    repeat (6) begin
      @(posedge clk);
      chk("t4_no_more", start, 0);
    end
    gseq.delete();
    q0.push_back(32'h13572468);
    q1.push_back(32'h24681357);
    drive();
    run(1, 0, 300);
    chk("t4_tie_req0", gseq.size() > 0 ? gseq[0] : 2'b11, 2'b01);
    // 5: stray tx_done while idle
    done = 1'b1;
    @(posedge clk);
    done = 1'b0;
    repeat (2) begin
      @(posedge clk);
      chk("t5_start", start, 0);
      chk("t5_busy", busy, 0);
      chk("t5_grant", grant, 0);
    end
`ifdef TX_WORD_TIMEOUT_EN
    // 6: withheld tx_done triggers the watchdog; req1 served next
    do_reset();
    gseq.delete();
    stall = 1'b1;
    q0.push_back(32'hCAFEF00D);
    q1.push_back(32'h5A5AA5A5);
    drive();
    run(2, 0, 400);
    chk("t6_timeouts", n_to, 1);
    chk("t6_order0", gseq.size() > 1 ? gseq[0] : 2'b11, 2'b01);
    chk("t6_order1", gseq.size() > 1 ? gseq[1] : 2'b11, 2'b10);
`else
    chk("t6_no_timeout", n_to, 0);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
